// File: rtl/alu32_seq_ctrl.sv
// Sequencing front end for a 32-bit combinational ALU: register file, one-command-at-a-time
// valid/ready intake, registered operands out, result/flag writeback with a done pulse.
module alu32_seq_ctrl #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_op,
  input  logic [31:0]   alu_result,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic          done,
  output logic          flag_c,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_v
);

  localparam int NREGS = 1 << AW;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   rf [NREGS];
  logic [AW-1:0] rd_q;

  // Handshake: a command transfers at a rising edge where cmd_valid && cmd_ready.
  // cmd_ready depends on state only, so the source may raise or drop cmd_valid freely.
  assign cmd_ready = (state == IDLE);
  assign rd_data   = rf[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_q   <= '0;
      done   <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) rf[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a  <= rf[cmd_ra];
            alu_b  <= rf[cmd_rb];
            alu_op <= cmd_op;
            rd_q   <= cmd_rd;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Placed after the host write so writeback wins on an address collision.
          rf[rd_q] <= alu_result;
          flag_c   <= alu_c;
          flag_n   <= alu_n;
          flag_z   <= alu_z;
          flag_v   <= alu_v;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Directed bench for alu32_seq_ctrl: a reference ALU closes the loop, a done-driven monitor
// checks result/flags against an expected queue, and directed checks cover timing and rf state.
module tb_alu32_seq_ctrl;

  localparam int AW = 3;
  localparam int W  = 36; // {result[31:0], c, n, z, v}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_ra = '0;
  logic [AW-1:0] cmd_rb = '0;
  logic [AW-1:0] cmd_rd = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [2:0]    alu_op;
  logic [31:0]   alu_result;
  logic          alu_c, alu_n, alu_z, alu_v;
  logic          done;
  logic          flag_c, flag_n, flag_z, flag_v;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  alu32_seq_ctrl #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .done(done), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  // Clock / reset-independent environment: clock and reference ALU.
  always #5 clk = ~clk;

  logic [32:0] sum;
  always_comb begin
    sum = '0;
    alu_result = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      3'b000: alu_result = ~alu_a;
      3'b001: alu_result = ~alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~(alu_a ^ alu_b);
      3'b110: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        alu_c = sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      default: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum[31:0];
        alu_c = sum[32];
        alu_v = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
    endcase
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected {result, flags} entry.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 36'(done), 36'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_result", 36'(alu_result), 36'(e[35:4]));
        check("sb_flags", 36'({flag_c, flag_n, flag_z, flag_v}), 36'(e[3:0]));
      end
    end
  end

  // Driver tasks: each is entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [AW-1:0] a, input logic [31:0] req);
    rd_addr = a;
    #1;
    check(name, 36'(rd_data), 36'(req));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 36'(cmd_ready), 36'd1);
  endtask

  // Issues one command; optional host write is presented during the EXEC cycle.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rd, input logic [31:0] exp_res, input logic [3:0] exp_cnzv,
                       input logic hw, input logic [AW-1:0] hw_addr, input logic [31:0] hw_data);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_ra = ra;
    cmd_rb = rb;
    cmd_rd = rd;
    exp_q.push_back({exp_res, exp_cnzv});
    step();
    cmd_valid = 1'b0;
    cmd_op = ~op;
    cmd_ra = ~ra;
    cmd_rb = ~rb;
    cmd_rd = ~rd;
    check("ready_in_exec", 36'(cmd_ready), 36'd0);
    check("alu_op_reg", 36'(alu_op), 36'(op));
    wr_en = hw;
    wr_addr = hw_addr;
    wr_data = hw_data;
    step();
    wr_en = 1'b0;
    check("done_latency", 36'(done), 36'd1);
    check("ready_in_done", 36'(cmd_ready), 36'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state
    #12;
    check("rst_ready", 36'(cmd_ready), 36'd1);
    check("rst_done", 36'(done), 36'd0);
    check("rst_flags", 36'({flag_c, flag_n, flag_z, flag_v}), 36'd0);
    check("rst_alu_ab_op", 36'({alu_a[0], alu_b[0], alu_op} | 5'(|alu_a) | 5'(|alu_b)), 36'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_rf", 3'(i), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("post_rst_ready", 36'(cmd_ready), 36'd1);

    // 2. Signed overflow on add
    host_wr(3'd1, 32'h7FFF_FFFF);
    host_wr(3'd2, 32'h0000_0001);
    issue(3'b110, 3'd1, 3'd2, 3'd3, 32'h8000_0000, 4'b0101, 1'b0, 3'd0, 32'd0);
    step();
    check("done_one_cycle", 36'(done), 36'd0);
    check_reg("t2_r3", 3'd3, 32'h8000_0000);
    check("alu_a_hold", 36'(alu_a), 36'(32'h7FFF_FFFF));

    // 3. Equal subtraction: zero with carry (no borrow)
    host_wr(3'd4, 32'd5);
    host_wr(3'd5, 32'd5);
    issue(3'b111, 3'd4, 3'd5, 3'd6, 32'h0000_0000, 4'b1010, 1'b0, 3'd0, 32'd0);
    check_reg("t3_r6", 3'd6, 32'h0000_0000);

    // 4. Back-to-back: second command accepted in the done cycle reads fresh r3
    host_wr(3'd3, 32'h0000_0000);
    issue(3'b110, 3'd1, 3'd2, 3'd3, 32'h8000_0000, 4'b0101, 1'b0, 3'd0, 32'd0);
    issue(3'b011, 3'd3, 3'd2, 3'd7, 32'h8000_0001, 4'b0100, 1'b0, 3'd0, 32'd0);
    check_reg("t4_r7", 3'd7, 32'h8000_0001);

    // 5a. Host write to the writeback address at E1: writeback wins
    issue(3'b110, 3'd4, 3'd5, 3'd3, 32'h0000_000A, 4'b0000, 1'b1, 3'd3, 32'hDEAD_BEEF);
    check_reg("t5a_r3", 3'd3, 32'h0000_000A);

    // 5b. Host write to a source register during EXEC: both writes land, operands unaffected
    issue(3'b111, 3'd4, 3'd1, 3'd3, 32'h8000_0006, 4'b0100, 1'b1, 3'd4, 32'hDEAD_BEEF);
    check_reg("t5b_r3", 3'd3, 32'h8000_0006);
    check_reg("t5b_r4", 3'd4, 32'hDEAD_BEEF);

    // 6. Reset in EXEC aborts the command
    host_wr(3'd3, 32'h1111_1111);
    check_reg("t6_r3_pre", 3'd3, 32'h1111_1111);
    cmd_valid = 1'b1;
    cmd_op = 3'b011;
    cmd_ra = 3'd1;
    cmd_rb = 3'd2;
    cmd_rd = 3'd3;
    step();
    cmd_valid = 1'b0;
    check("t6_in_exec", 36'(cmd_ready), 36'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_ready_rst", 36'(cmd_ready), 36'd1);
    check("t6_flags_rst", 36'({flag_c, flag_n, flag_z, flag_v}), 36'd0);
    step();
    check("t6_done_rst", 36'(done), 36'd0);
    reset = 1'b0;
    step();
    check("t6_done_after", 36'(done), 36'd0);
    check("t6_ready_after", 36'(cmd_ready), 36'd1);
    check_reg("t6_r3", 3'd3, 32'h0000_0000);
    check_reg("t6_r1", 3'd1, 32'h0000_0000);
    step();
    step();

    check("sb_drained", 36'(exp_q.size()), 36'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
